prog_fetch_unit: RTL and testbench
==================================

Name: prog_fetch_unit

Overview:
- Instruction-fetch initiator for the program-memory window, i.e. the requesting side of the program address decoder.
- Holds the PC and issues word addresses with a read strobe to the decoder and program memory.
- Waits a fixed read latency, captures the instruction and presents it to the decode stage over a valid/ready handshake.
- Checks every PC against the program window and alignment, and raises a sticky fault instead of issuing an illegal fetch.

Parameters:
- PROG_BASE, 32'h0000_18C0, first byte address of the program window (inclusive).
- PROG_LAST, 32'h0000_1CBF, last byte address of the program window (inclusive).
- RESET_PC, 32'h0000_18C0, PC value loaded by reset.
- MEM_LATENCY, 1, cycles from rd_en high to valid rdata; legal range 1..4.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- address  out  32  fetch byte address; always equals the PC register.
- rd_en  out  1  read strobe to the program decoder/memory; one-cycle pulse per fetch.
- rdata  in  32  instruction word returned by memory MEM_LATENCY cycles after rd_en.
- inst  out  32  captured instruction.
- inst_pc  out  32  address that inst was fetched from.
- inst_valid  out  1  inst/inst_pc valid toward decode.
- inst_ready  in  1  decode accepts inst this cycle.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  32  redirect target.
- fault  out  1  sticky fetch fault: PC outside the window or not word-aligned.

Behaviour:
- Reset (rst=1 at a CLK edge):
  - PC=RESET_PC, state=ISSUE, inst=0, inst_pc=0, inst_valid=0, fault=0, latency counter=0.
  - rd_en is forced to 0 while rst=1.
- PC legality (legal): PROG_BASE <= PC <= PROG_LAST and PC[1:0]==2'b00. Comparisons are unsigned 32-bit.
- States ISSUE, WAIT, HOLD, FAULT. Only ISSUE drives rd_en combinationally; all other outputs are registered.
- ISSUE:
  - If legal: rd_en=1, counter<=MEM_LATENCY-1, go to WAIT.
  - If not legal: rd_en=0, fault<=1, go to FAULT.
- WAIT:
  - While counter!=0, decrement.
  - When counter==0, on that edge: inst<=rdata, inst_pc<=PC, inst_valid<=1, PC<=PC+4, go to HOLD.
  - Fetch latency is therefore rd_en high at edge N, inst_valid high after edge N+MEM_LATENCY.
- HOLD:
  - inst, inst_pc and inst_valid stay stable while inst_ready=0.
  - When inst_valid && inst_ready: inst_valid<=0, go to ISSUE. No new fetch is issued while an instruction is held.
- FAULT:
  - rd_en=0, inst_valid=0, fault=1; remain here until redirect or reset.
- PC+4 wraps modulo 2^32. Stepping past PROG_LAST is caught by the next ISSUE check and faults.
- Redirect (redirect_valid=1), valid in any state:
  - PC<=redirect_pc, fault<=0, inst_valid<=0, counter<=0, go to ISSUE.
  - An in-flight read is squashed: its rdata is never captured.
  - Priority: redirect over the normal transition. If redirect and a HOLD handshake land in the same cycle, the handshake counts as a completed transfer and the PC still takes redirect_pc.
  - Redirect during ISSUE: that cycle's rd_en is still driven from the old PC; the result is squashed.
- rst has priority over redirect. Reset mid-WAIT or mid-HOLD discards everything; the first rd_en comes in the first cycle with rst=0.

Decomposition:
- Shared package prog_fetch_pkg:
  - State enum (ISSUE/WAIT/HOLD/FAULT).
  - Default window constants PROG_BASE_DEF=32'h18C0 and PROG_LAST_DEF=32'h1CBF.
  - INSTR_BYTES=4.
  - These constants are shared with the program address decoder so the two agree on the window.
- One sub-module, prog_window_check: combinational; inputs pc; parameters PROG_BASE/PROG_LAST; outputs in_range, aligned, legal.

Test Plan:
1. Reset release, memory returns 32'h2008_0005 at 0x18C0 (MEM_LATENCY=1), inst_ready=1 -> rd_en pulses with address 0x18C0 in the first cycle after reset. One edge later inst_valid=1, inst=32'h2008_0005, inst_pc=0x18C0, and address becomes 0x18C4.
2. Backpressure: hold inst_ready=0 for 5 cycles while inst_valid=1 -> inst/inst_pc stable, rd_en stays 0. Raise inst_ready -> one transfer, then rd_en with address 0x18C4 next cycle.
3. Upper boundary: redirect to 0x1CBC -> fetch succeeds with inst_pc=0x1CBC. After the handshake, PC=0x1CC0 -> fault=1, rd_en never asserted for 0x1CC0, inst_valid=0.
4. Lower boundary and misalignment:
   - Redirect to 0x18BC -> fault=1, no rd_en.
   - Redirect to 0x18C2 -> fault=1, no rd_en.
   - Redirect to 0x18C0 -> fault=0 and rd_en at 0x18C0.
5. Squash: MEM_LATENCY=3, redirect to 0x1A00 one cycle after rd_en for 0x18C0 -> 0x18C0 data is never presented. Next rd_en carries address 0x1A00, then inst_pc=0x1A00.
6. Reset mid-HOLD (inst_valid=1, PC=0x18C8) -> the edge with rst=1 clears inst_valid, inst and inst_pc; address=0x18C0. The first cycle after release shows rd_en=1.

Source files
------------

// File: rtl/prog_fetch_pkg.sv
// Shared fetch definitions: FSM state encoding and the default program window,
// kept in one place so the fetch unit and the program address decoder agree.
package prog_fetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PROG_BASE_DEF = 32'h0000_18C0;
    localparam logic [31:0] PROG_LAST_DEF = 32'h0000_1CBF;
    localparam logic [31:0] INSTR_BYTES   = 32'd4;

endpackage

// File: rtl/prog_window_check.sv
// Combinational legality check of a fetch PC against the program window.
// Bounds are inclusive byte addresses, compared as unsigned 32-bit values.
module prog_window_check
    import prog_fetch_pkg::*;
#(
    parameter logic [31:0] PROG_BASE = PROG_BASE_DEF,
    parameter logic [31:0] PROG_LAST = PROG_LAST_DEF
) (
    input  logic [31:0] pc,
    output logic        in_range,
    output logic        aligned,
    output logic        legal
);

    assign in_range = (pc >= PROG_BASE) && (pc <= PROG_LAST);
    assign aligned  = (pc[1:0] == 2'b00);
    assign legal    = in_range && aligned;

endmodule

// File: rtl/prog_fetch_unit.sv
// Instruction-fetch initiator for the program window. Holds the PC, issues a
// one-cycle read strobe, waits MEM_LATENCY cycles, captures the word and hands
// it to decode over valid/ready. An illegal PC raises a sticky fault instead
// of a read; only a redirect or reset leaves the fault state.
module prog_fetch_unit
    import prog_fetch_pkg::*;
#(
    parameter logic [31:0] PROG_BASE   = PROG_BASE_DEF,
    parameter logic [31:0] PROG_LAST   = PROG_LAST_DEF,
    parameter logic [31:0] RESET_PC    = PROG_BASE_DEF,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        rst,
    output logic [31:0] address,
    output logic        rd_en,
    input  logic [31:0] rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    // Counter is loaded with MEM_LATENCY-1 so capture lands MEM_LATENCY edges
    // after the edge that sampled rd_en (latency range 1..4 fits in 2 bits).
    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  pc;
    logic [1:0]   lat_cnt;
    logic         pc_legal;
    logic         pc_in_range;
    logic         pc_aligned;
    logic         unused_win;

    prog_window_check #(
        .PROG_BASE (PROG_BASE),
        .PROG_LAST (PROG_LAST)
    ) u_window (
        .pc       (pc),
        .in_range (pc_in_range),
        .aligned  (pc_aligned),
        .legal    (pc_legal)
    );

    // The individual window bits are only of interest when probing a fault.
    assign unused_win = pc_in_range ^ pc_aligned;

    assign address = pc;

    // State register; reset returns to ISSUE.
    always_ff @(posedge CLK) begin
        if (rst) state <= ST_ISSUE;
        else     state <= state_nxt;
    end

    // Next state and the read strobe. rd_en follows the current PC even in a
    // redirect cycle; that read is squashed because the counter restarts.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (pc_legal) begin
                    rd_en     = !rst;
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_WAIT:  if (lat_cnt == 2'd0) state_nxt = ST_HOLD;
            ST_HOLD:  if (inst_valid && inst_ready) state_nxt = ST_ISSUE;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_ISSUE;
        endcase
        if (redirect_valid) state_nxt = ST_ISSUE;
    end

    // PC, latency counter, captured instruction and fault flag. Redirect wins
    // over every normal transition; a HOLD handshake in the same cycle still
    // completes because inst_valid is cleared either way.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pc         <= RESET_PC;
            lat_cnt    <= 2'd0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            lat_cnt    <= 2'd0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    if (pc_legal) lat_cnt <= LAT_INIT;
                    else          fault   <= 1'b1;
                end
                ST_WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        inst       <= rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + INSTR_BYTES;
                    end
                end
                ST_HOLD: begin
                    if (inst_valid && inst_ready) inst_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Bench for prog_fetch_unit: two instances (read latency 1 and 3) share the
// same stimulus. Each redirect/reset pushes the sequence of word addresses the
// program should deliver from that target up to the end of the window; a
// per-lane monitor pops on every handshake and checks read addresses, data,
// hold stability and the fault condition.
module tb_prog_fetch_unit;
    import prog_fetch_pkg::*;

    localparam int          NL      = 2;
    localparam logic [31:0] BASE    = 32'h0000_18C0;
    localparam logic [31:0] LAST    = 32'h0000_1CBF;
    localparam logic [31:0] RST_PC  = 32'h0000_18C0;
    localparam logic [32:0] SEG_END = 33'h1_0000_0000;

    bit          CLK;
    logic        rst;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        rd_en      [NL];
    logic        inst_valid [NL];
    logic        fault      [NL];
    logic [31:0] address    [NL];
    logic [31:0] inst       [NL];
    logic [31:0] inst_pc    [NL];
    logic [31:0] rdata      [NL];

    int n_checks = 0;
    int n_pass   = 0;

    // Expected delivery order per lane; SEG_END entries separate the
    // sequences started by successive redirects/resets.
    logic [32:0] exp_q [NL][$];

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {1'b0, act}, {1'b0, exp});
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {32'b0, act}, {32'b0, exp});
    endtask

    function automatic bit model_legal(input logic [31:0] a);
        return (a >= BASE) && (a <= LAST) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_18C0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic push_all(input logic [31:0] start);
        logic [31:0] a;
        for (int l = 0; l < NL; l++) begin
            exp_q[l].push_back(SEG_END);
            a = start;
            while (model_legal(a)) begin
                exp_q[l].push_back({1'b0, a});
                a = a + 32'd4;
            end
        end
    endtask

    function automatic logic [32:0] front(input int l);
        if (exp_q[l].size() == 0) return SEG_END;
        return exp_q[l][0];
    endfunction

    task automatic drop_segment(input int l);
        logic [32:0] e;
        while (exp_q[l].size() > 0) begin
            e = exp_q[l].pop_front();
            if (e[32]) break;
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [3:0]        pv = '0;
        logic [3:0][31:0]  pa;
        logic [31:0]       junk;
        logic              p_hold = 1'b0;
        logic              p_redir = 1'b0;
        logic [31:0]       p_inst;
        logic [31:0]       p_pc;

        prog_fetch_unit #(
            .PROG_BASE   (BASE),
            .PROG_LAST   (LAST),
            .RESET_PC    (RST_PC),
            .MEM_LATENCY (LAT)
        ) u_dut (
            .CLK            (CLK),
            .rst            (rst),
            .address        (address[g]),
            .rd_en          (rd_en[g]),
            .rdata          (rdata[g]),
            .inst           (inst[g]),
            .inst_pc        (inst_pc[g]),
            .inst_valid     (inst_valid[g]),
            .inst_ready     (inst_ready),
            .redirect_valid (redirect_valid),
            .redirect_pc    (redirect_pc),
            .fault          (fault[g])
        );

        // Program memory: data for a read is on rdata for exactly one cycle,
        // LAT edges after rd_en was sampled; otherwise rdata is random junk.
        always @(posedge CLK) begin
            pv   <= {pv[2:0], rd_en[g]};
            pa   <= {pa[2:0], address[g]};
            junk <= $urandom;
        end
        assign rdata[g] = pv[LAT-1] ? mem_word(pa[LAT-1]) : junk;

        // Scoreboard monitor.
        always @(negedge CLK) begin
            if (rst) begin
                check1($sformatf("L%0d rd_en during reset", g), rd_en[g], 1'b0);
                drop_segment(g);
                p_hold  <= 1'b0;
                p_redir <= 1'b0;
            end else begin
                if (p_hold) begin
                    check1($sformatf("L%0d held valid", g), inst_valid[g], 1'b1);
                    check32($sformatf("L%0d held inst", g), inst[g], p_inst);
                    check32($sformatf("L%0d held inst_pc", g), inst_pc[g], p_pc);
                end
                if (p_redir)
                    check1($sformatf("L%0d valid after redirect", g), inst_valid[g], 1'b0);
                if (rd_en[g])
                    check($sformatf("L%0d rd_en address", g), {1'b0, address[g]}, front(g));
                if (inst_valid[g] && inst_ready) begin
                    check($sformatf("L%0d inst_pc", g), {1'b0, inst_pc[g]}, front(g));
                    if (!front(g)) begin end
                    if (front(g) != SEG_END) begin
                        check32($sformatf("L%0d inst", g), inst[g], mem_word(inst_pc[g]));
                        void'(exp_q[g].pop_front());
                    end
                end
                if (fault[g])
                    check($sformatf("L%0d fault with fetches pending", g), front(g), SEG_END);
                p_hold  <= inst_valid[g] && !inst_ready && !redirect_valid;
                p_inst  <= inst[g];
                p_pc    <= inst_pc[g];
                p_redir <= redirect_valid;
                if (redirect_valid) drop_segment(g);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        push_all(t);
        tick();
        redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(5))
            0, 1, 2: t = BASE + 32'(4 * $urandom_range(255));
            3:       t = LAST - 32'd15 + $urandom_range(20);
            4:       t = BASE - 32'd8 + $urandom_range(12);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin : stim
        bit seen;
        int bad;
        int lat;
        logic [31:0] bad_pc [2];
        bad_pc[0] = 32'h0000_18BC;
        bad_pc[1] = 32'h0000_18C2;

        rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick();

        // Reset state
        push_all(RST_PC);
        @(negedge CLK);
        check1("reset inst_valid", inst_valid[0], 1'b0);
        check1("reset fault", fault[0], 1'b0);
        check32("reset inst", inst[0], 32'd0);
        check32("reset inst_pc", inst_pc[0], 32'd0);
        check32("reset address", address[0], RST_PC);
        check1("reset rd_en forced low", rd_en[0], 1'b0);
        tick();
        rst = 1'b0;

        // First fetch after reset
        @(negedge CLK);
        check1("T1 rd_en after reset", rd_en[0], 1'b1);
        check32("T1 first address", address[0], 32'h0000_18C0);
        check1("T1 rd_en after reset lat3", rd_en[1], 1'b1);
        tick();
        @(negedge CLK);
        check1("T1 not yet valid", inst_valid[0], 1'b0);
        tick();
        inst_ready = 1'b0;
        @(negedge CLK);
        check1("T1 inst_valid", inst_valid[0], 1'b1);
        check32("T1 inst", inst[0], 32'h2008_0005);
        check32("T1 inst_pc", inst_pc[0], 32'h0000_18C0);
        check32("T1 address advanced", address[0], 32'h0000_18C4);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge CLK);
            check1("T2 valid held", inst_valid[0], 1'b1);
            check32("T2 inst held", inst[0], 32'h2008_0005);
            check32("T2 inst_pc held", inst_pc[0], 32'h0000_18C0);
            check1("T2 no fetch while held", rd_en[0], 1'b0);
        end
        tick();
        inst_ready = 1'b1;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        check1("T2 rd_en after transfer", rd_en[0], 1'b1);
        check32("T2 next address", address[0], 32'h0000_18C4);
        check1("T2 valid dropped", inst_valid[0], 1'b0);
        tick();

        // Upper boundary
        redirect_to(32'h0000_1CBC);
        seen = 1'b0; bad = 0;
        for (int i = 0; i < 20 && !fault[0]; i++) begin
            @(negedge CLK);
            if (rd_en[0] && address[0] == 32'h0000_1CC0) bad++;
            if (inst_valid[0] && !seen) begin
                seen = 1'b1;
                check32("T3 inst_pc last word", inst_pc[0], 32'h0000_1CBC);
                check32("T3 inst last word", inst[0], mem_word(32'h0000_1CBC));
            end
            tick();
        end
        @(negedge CLK);
        check1("T3 last word delivered", seen, 1'b1);
        check1("T3 fault past window", fault[0], 1'b1);
        check1("T3 no valid in fault", inst_valid[0], 1'b0);
        check32("T3 faulting address", address[0], 32'h0000_1CC0);
        check32("T3 rd_en count for 0x1CC0", 32'(bad), 32'd0);
        tick();

        // Lower boundary and misalignment
        for (int k = 0; k < 2; k++) begin
            redirect_to(bad_pc[k]);
            bad = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                if (rd_en[0]) bad++;
                tick();
            end
            @(negedge CLK);
            check1($sformatf("T4 fault %h", bad_pc[k]), fault[0], 1'b1);
            check32($sformatf("T4 rd_en count %h", bad_pc[k]), 32'(bad), 32'd0);
            tick();
        end
        redirect_to(32'h0000_18C0);
        @(negedge CLK);
        check1("T4 fault cleared", fault[0], 1'b0);
        check1("T4 rd_en at base", rd_en[0], 1'b1);
        check32("T4 address base", address[0], 32'h0000_18C0);
        check1("T4 rd_en at base lat3", rd_en[1], 1'b1);
        tick();

        // Squash of an in-flight read (latency-3 lane)
        redirect_to(32'h0000_1A00);
        @(negedge CLK);
        check1("T5 rd_en after squash", rd_en[1], 1'b1);
        check32("T5 address after squash", address[1], 32'h0000_1A00);
        seen = 1'b0; lat = -1;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            @(negedge CLK);
            if (inst_valid[1]) begin
                seen = 1'b1;
                lat  = i;
                check32("T5 inst_pc after squash", inst_pc[1], 32'h0000_1A00);
                check32("T5 inst after squash", inst[1], mem_word(32'h0000_1A00));
            end
        end
        check1("T5 delivered", seen, 1'b1);
        check32("T5 latency edges", 32'(lat), 32'd3);
        tick();

        // Reset while holding
        inst_ready = 1'b0;
        redirect_to(32'h0000_18C4);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (inst_valid[0]) seen = 1'b1;
            tick();
        end
        @(negedge CLK);
        check1("T6 holding before reset", inst_valid[0], 1'b1);
        check32("T6 pc before reset", address[0], 32'h0000_18C8);
        tick();
        rst = 1'b1;
        push_all(RST_PC);
        @(negedge CLK);
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        @(negedge CLK);
        check1("T6 valid cleared", inst_valid[0], 1'b0);
        check32("T6 inst cleared", inst[0], 32'd0);
        check32("T6 inst_pc cleared", inst_pc[0], 32'd0);
        check32("T6 address reset", address[0], RST_PC);
        check1("T6 rd_en after release", rd_en[0], 1'b1);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            inst_ready = ($urandom_range(3) != 0);
            lat = $urandom_range(199);
            if (lat == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) begin
                    push_all(RST_PC);
                    tick();
                end
                rst = 1'b0;
            end else if (lat < 10) begin
                redirect_to(pick_target());
            end else begin
                tick();
            end
        end
        inst_ready = 1'b1;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
